// File: rtl/bcd_display_scan_4digits_pkg.sv
// Shared constants for the 4-digit BCD display scanner: segment patterns
// ({g,f,e,d,c,b,a}, active-low), digit count and default refresh divider.
package bcd_display_scan_4digits_pkg;

  localparam int unsigned NDIGITS             = 4;
  localparam int unsigned REFRESH_DIV_DEFAULT = 50000;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_display_scan_4digits_bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment decoder; values 10-15 show "E".
module bcd_display_scan_4digits_bcd_to_7seg
  import bcd_display_scan_4digits_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_E;
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_E;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan_4digits.sv
// Time-multiplexed common-anode 4-digit display for a packed-BCD sum; new data
// is committed only at frame boundaries and acknowledged with a one-cycle pulse.
module bcd_display_scan_4digits
  import bcd_display_scan_4digits_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEFAULT,
  parameter int unsigned CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] sum_in,
  input  logic        cout_in,
  input  logic        blank_lz,
  output logic        load_ack,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp
);

  localparam int unsigned IDX_W = $clog2(NDIGITS);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      shadow_q, shadow_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      pend_data_q, pend_data_d;
  logic             pend_ovf_q, pend_ovf_d;
  logic             pend_q, pend_d;
  logic             ack_q, ack_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             dp_q, dp_d;

  logic        tick, commit, blank;
  logic [3:0]  digit;
  logic [15:0] upper;
  logic [6:0]  dec_seg;

  assign tick   = (cnt_q == CNT_W'(REFRESH_DIV - 1));
  assign commit = tick && (idx_q == IDX_W'(NDIGITS - 1));

  // Scan counter, pending register and commit handshake.
  always_comb begin
    cnt_d       = tick ? '0 : cnt_q + 1'b1;
    idx_d       = tick ? idx_q + 1'b1 : idx_q;
    shadow_d    = shadow_q;
    ovf_d       = ovf_q;
    pend_data_d = pend_data_q;
    pend_ovf_d  = pend_ovf_q;
    pend_d      = pend_q;
    ack_d       = 1'b0;
    if (commit && (load || pend_q)) begin
      shadow_d = load ? sum_in : pend_data_q;
      ovf_d    = load ? cout_in : pend_ovf_q;
      pend_d   = 1'b0;
      ack_d    = 1'b1;
    end else if (load) begin
      pend_data_d = sum_in;
      pend_ovf_d  = cout_in;
      pend_d      = 1'b1;
    end
  end

  // A digit is a leading zero iff it and all higher digits are zero.
  always_comb begin
    digit = shadow_q[{idx_q, 2'b00} +: 4];
    upper = shadow_q >> {idx_q, 2'b00};
    blank = blank_lz && (idx_q != '0) && (upper == 16'h0000);
  end

  bcd_display_scan_4digits_bcd_to_7seg u_dec (
    .digit_i (digit),
    .seg_o   (dec_seg)
  );

  always_comb begin
    seg_d = blank ? SEG_BLANK : dec_seg;
    an_d  = ~(4'b0001 << idx_q);
    dp_d  = ~((idx_q == IDX_W'(NDIGITS - 1)) && ovf_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      ovf_q       <= 1'b0;
      pend_data_q <= '0;
      pend_ovf_q  <= 1'b0;
      pend_q      <= 1'b0;
      ack_q       <= 1'b0;
      seg_q       <= SEG_BLANK;
      an_q        <= 4'b1111;
      dp_q        <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      ovf_q       <= ovf_d;
      pend_data_q <= pend_data_d;
      pend_ovf_q  <= pend_ovf_d;
      pend_q      <= pend_d;
      ack_q       <= ack_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      dp_q        <= dp_d;
    end
  end

  assign load_ack = ack_q;
  assign seg      = seg_q;
  assign an       = an_q;
  assign dp       = dp_q;

endmodule

// File: tb/tb_bcd_display_scan_4digits.sv
// Directed bench for the 4-digit display scanner, checked every cycle against
// a cycle-count based model plus literal spot checks.
module tb_bcd_display_scan_4digits;

  localparam int unsigned RDIV  = 4;
  localparam int unsigned FRAME = RDIV * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] sum_in = 16'h0000;
  logic        cout_in = 1'b0;
  logic        blank_lz = 1'b0;
  logic        load_ack;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;

  int vectors = 0;
  int miscompares = 0;
  int ack_cnt = 0;

  bcd_display_scan_4digits #(
    .REFRESH_DIV (RDIV),
    .CNT_W       (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .sum_in   (sum_in),
    .cout_in  (cout_in),
    .blank_lz (blank_lz),
    .load_ack (load_ack),
    .seg      (seg),
    .an       (an),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16];
  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0000110;
  end

  // Model: k counts clock edges since reset release; displayed digit and
  // frame boundaries follow from k by plain arithmetic.
  int          k = 0;
  bit          started = 1'b0;
  logic [15:0] m_shadow, m_pdata, sh;
  logic        m_ovf, m_povf, m_pend;
  logic [6:0]  e_seg;
  logic [3:0]  e_an;
  logic        e_dp, e_ack;
  int          m_idx;

  always @(posedge clk) begin
    started = 1'b1;
    if (!rst_n) begin
      k = 0; m_shadow = 16'h0; m_ovf = 1'b0; m_pend = 1'b0;
      m_pdata = 16'h0; m_povf = 1'b0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_ack = 1'b0;
    end else begin
      m_idx = (k / RDIV) % 4;
      e_an  = ~(4'b0001 << m_idx);
      sh    = m_shadow >> (4 * m_idx);
      e_seg = (blank_lz && m_idx != 0 && sh == 16'h0) ? 7'h7F : seg_tab[sh[3:0]];
      e_dp  = !(m_idx == 3 && m_ovf);
      e_ack = 1'b0;
      if ((k % FRAME) == FRAME - 1 && (load || m_pend)) begin
        m_shadow = load ? sum_in : m_pdata;
        m_ovf    = load ? cout_in : m_povf;
        m_pend   = 1'b0;
        e_ack    = 1'b1;
      end else if (load) begin
        m_pdata = sum_in; m_povf = cout_in; m_pend = 1'b1;
      end
      k++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      vectors++;
      if (an !== e_an) begin
        miscompares++;
        $display("FAIL an t=%0t got %b want %b", $time, an, e_an);
      end
      if (seg !== e_seg) begin
        miscompares++;
        $display("FAIL seg t=%0t an=%b got %b want %b", $time, an, seg, e_seg);
      end
      if (dp !== e_dp) begin
        miscompares++;
        $display("FAIL dp t=%0t an=%b got %b want %b", $time, an, dp, e_dp);
      end
      if (load_ack !== e_ack) begin
        miscompares++;
        $display("FAIL load_ack t=%0t got %b want %b", $time, load_ack, e_ack);
      end
      if (load_ack === 1'b1) ack_cnt++;
    end
  end

  task automatic pin(input string name, input logic [6:0] act, input logic [6:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %b want %b", name, act, exp);
    end
  endtask

  task automatic wait_an(input logic [3:0] target);
    int n = 0;
    @(negedge clk);
    while (an !== target && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (an !== target) begin
      miscompares++;
      $display("FAIL wait_an timeout got %b want %b", an, target);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic c);
    load = 1'b1; sum_in = v; cout_in = c;
    @(negedge clk);
    load = 1'b0;
  endtask

  int ack_base;

  initial begin
    repeat (3) @(negedge clk);
    pin("reset_an", {3'b000, an}, 7'b0001111);
    pin("reset_seg", seg, 7'h7F);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    wait_an(4'b1110);
    pin("post_reset_d0", seg, 7'b1000000);
    pin("no_ack_after_reset", 7'(ack_cnt), 7'd0);

    // 1234 loaded mid-frame
    repeat (2) @(negedge clk);
    ack_base = ack_cnt;
    do_load(16'h1234, 1'b0);
    repeat (2 * FRAME) @(negedge clk);
    wait_an(4'b1110);
    pin("d0_is_4", seg, 7'b0011001);
    wait_an(4'b0111);
    pin("d3_is_1", seg, 7'b1111001);
    pin("dp_off", {6'b0, dp}, 7'd1);
    pin("ack_1234", 7'(ack_cnt - ack_base), 7'd1);

    // 0001 with carry, leading-zero blanking
    blank_lz = 1'b1;
    wait_an(4'b1110);
    do_load(16'h0001, 1'b1);
    repeat (2 * FRAME) @(negedge clk);
    wait_an(4'b1101);
    pin("lz_d1_blank", seg, 7'h7F);
    wait_an(4'b0111);
    pin("lz_d3_blank", seg, 7'h7F);
    pin("dp_lit", {6'b0, dp}, 7'd0);
    wait_an(4'b1110);
    pin("lz_d0_is_1", seg, 7'b1111001);
    pin("dp_d0_off", {6'b0, dp}, 7'd1);

    // Two loads within one frame: only the last is committed, one ack
    wait_an(4'b1110);
    ack_base = ack_cnt;
    do_load(16'h1111, 1'b0);
    @(negedge clk);
    do_load(16'h9999, 1'b0);
    repeat (2 * FRAME) @(negedge clk);
    wait_an(4'b1011);
    pin("d2_is_9", seg, 7'b0010000);
    pin("ack_double", 7'(ack_cnt - ack_base), 7'd1);

    // Invalid BCD digit shows E and stops blanking below it
    wait_an(4'b1110);
    do_load(16'h00A5, 1'b0);
    repeat (2 * FRAME) @(negedge clk);
    wait_an(4'b1101);
    pin("d1_is_E", seg, 7'b0000110);
    wait_an(4'b1011);
    pin("d2_blank", seg, 7'h7F);
    wait_an(4'b1110);
    pin("d0_is_5", seg, 7'b0010010);

    // Reset with a load pending discards it
    wait_an(4'b1110);
    ack_base = ack_cnt;
    do_load(16'h4321, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * FRAME) @(negedge clk);
    pin("ack_after_reset", 7'(ack_cnt - ack_base), 7'd0);
    wait_an(4'b1110);
    pin("rst_d0_zero", seg, 7'b1000000);
    wait_an(4'b1101);
    pin("rst_d1_blank", seg, 7'h7F);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_display_scan_4digits.md
Name: bcd_display_scan_4digits

Overview:
Downstream consumer of the 4-digit BCD adder result. Latches the 16-bit packed-BCD sum and carry-out and drives a time-multiplexed, common-anode 4-digit 7-segment display. A load/ack handshake commits new data only at frame boundaries, so a digit never shows a value from a partially updated frame. Optional leading-zero blanking is provided, and the carry-out lights the decimal point on digit 3.

Parameters:
REFRESH_DIV, 50000, clock cycles each digit stays lit (must be >= 2)
CNT_W, 16, prescaler width (must satisfy 2**CNT_W >= REFRESH_DIV)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
load  in  1  one-cycle request to display sum_in/cout_in
sum_in  in  16  packed BCD; [3:0] is the least significant digit
cout_in  in  1  adder carry-out (overflow indicator)
blank_lz  in  1  1 = blank leading zeros
load_ack  out  1  one-cycle pulse when loaded data is committed to the display
seg  out  7  {g,f,e,d,c,b,a}, active-low
an  out  4  digit anodes, active-low one-hot; an[i] is digit i
dp  out  1  decimal point, active-low

Behaviour:
- Reset is synchronous; while rst_n=0 at a rising clk edge:
  - prescaler=0, digit index idx=0, shadow digits=0, shadow ovf=0, pending=0.
  - Outputs: an=4'b1111, seg=7'h7F, dp=1, load_ack=0.
- Reset mid-frame or with a load pending discards the pending data; no ack is issued.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick = (prescaler==REFRESH_DIV-1).
  - On tick, idx advances 0->1->2->3->0.
- Frame boundary (commit) = tick && idx==3.
- Handshake:
  - load=1 copies sum_in/cout_in into the pending register and sets pending.
  - A later load before commit overwrites the pending data; only the last value is committed, with one ack.
  - At the commit cycle, if pending=1 or load=1: shadow <= pending data, or sum_in/cout_in directly if load=1 in that same cycle (new load wins). pending clears, and load_ack=1 on the next cycle for exactly one cycle.
  - No commit occurs without a load.
- Output stage is registered: seg/an/dp reflect idx from the previous cycle, so an switches one cycle after idx changes.
  - an = ~(4'b0001 << idx).
  - seg = decode(shadow digit[idx]), or blank (7'h7F) if blanked.
- Decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any value 10-15 shows "E" = 0000110 (invalid BCD; never blanked).
- Leading-zero blanking (blank_lz=1): digit i (i=3..1) is blanked iff it and every higher digit are 0. Digit 0 is never blanked. blank_lz is sampled live, not shadowed.
- dp = 0 (lit) only while idx==3 is displayed and shadow ovf=1; otherwise dp=1.
- First display after reset: digit 0 shows "0"; digits 3..1 show "0", or are blank when blank_lz=1.

Decomposition:
- Shared package:
  - segment-pattern constants SEG_0..SEG_9, SEG_E, SEG_BLANK
  - digit-count constant NDIGITS=4
  - default REFRESH_DIV
- Natural sub-module: bcd_to_7seg (combinational 4-bit decoder with an invalid -> "E" mapping). It is instantiated once on the muxed digit.

Test Plan (bench uses REFRESH_DIV=4):
- Reset held 3 cycles, then released -> an=1111 during reset. After release, an cycles 1110,1101,1011,0111 every 4 cycles. seg=1000000 on digit 0; load_ack never pulses.
- load with sum_in=16'h1234, cout_in=0 mid-frame -> display unchanged until the idx 3->0 commit. load_ack pulses once the next cycle. Digits then show 4,3,2,1 and dp stays 1.
- load 16'h0001 with cout_in=1 and blank_lz=1 -> after commit, digits 3..1 show 7'h7F and digit 0 shows 1111001. dp=0 only while an=0111.
- Two loads in one frame (16'h1111, then 16'h9999) -> a single load_ack; the display shows 9999.
- load 16'h00A5 -> digit 1 shows "E" (0000110) even with blank_lz=1; digit 0 shows 5; digits 3..2 are blanked.
- Assert rst_n=0 while a load is pending -> no load_ack. After release, the display shows zeros and the pending data is lost.
